line_clear_engine: RTL and testbench
====================================

Name: line_clear_engine

Overview:
- Sits directly downstream of block_logic, between the active-piece logic and the board row storage.
- On a piece-lock request it writes the locked tetromino's four cells into the board, then scans rows bottom-to-top and compacts out full rows.
- Fills vacated top rows with EMPTY and updates score and line totals.
- Drives BOARD_BUSY while working, so block_logic freezes for the duration.

Parameters:
- ROWS, 20, board height in rows
- COLS, 10, board width in cells
- COLOR_W, 3, bits per cell (width of block_color)
- SCORE_MAX, 999999, saturation limit for score

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  asynchronous, active-low reset
- lock_req  in  1  one-cycle pulse: current piece has landed (get_new_block from block_logic)
- lock_x  in  20  four 5-bit x coords {c3,c2,c1,c0} of the landed piece
- lock_y  in  20  four 5-bit y coords, same packing
- lock_color  in  COLOR_W  piece color (block_color)
- row_rd_en  out  1  board row read strobe
- row_rd_addr  out  5  row index to read
- row_rd_data  in  COLS*COLOR_W  row contents; valid exactly 1 cycle after row_rd_en
- row_wr_en  out  1  board row write strobe
- row_wr_addr  out  5  row index to write
- row_wr_data  out  COLS*COLOR_W  row contents to write
- BOARD_BUSY  out  1  engine active
- clear_done  out  1  one-cycle pulse when the operation completes
- lines_cleared  out  3  rows removed by the last operation (0..4)
- lines_total  out  16  saturating running line count
- score  out  20  saturating score
- game_over  out  1  sticky top-out flag

Behaviour:
- Reset (async, active-low):
  - FSM to IDLE.
  - All outputs 0.
  - Cell/row counters 0.
- Cell encoding: EMPTY = 0. A row is full iff all COLS cells are nonzero. Cell k of a row occupies bits [k*COLOR_W +: COLOR_W].
- Accepting a request:
  - lock_req is sampled only in IDLE; ignored in every other state.
  - Acceptance latches lock_x, lock_y, lock_color.
  - BOARD_BUSY rises the cycle after acceptance and stays high until the cycle after clear_done.
- FSM states:
  - IDLE: wait for lock_req. Next: LK_RD.
  - LK_RD, LK_WAIT, LK_WR: read-modify-write for cell i = 0..3.
    - LK_RD: assert row_rd_en, addr = y_i.
    - LK_WAIT: one-cycle data latency.
    - LK_WR: write row y_i with cell x_i = lock_color, all other cells unchanged.
    - Two cells in the same row are handled correctly because each write commits before the next read.
    - A cell with x_i >= COLS or y_i >= ROWS is skipped: 0 cycles, no access.
    - After i = 3, go to SC_RD with src = dst = ROWS-1 and cleared = 0.
  - SC_RD, SC_WAIT, SC_EVAL: compaction scan.
    - SC_RD: read row src. SC_WAIT: one-cycle data latency.
    - SC_EVAL, row full: cleared++, no write.
    - SC_EVAL, row not full: if src != dst, write row dst with the read data; then dst--.
    - Every SC_EVAL: src--. When src wraps past 0, go to FILL.
  - FILL: for each row r with cleared > 0 and 0 <= r <= dst, write EMPTY, one row per cycle. Skip the state if cleared == 0.
  - DONE: pulse clear_done; update lines_cleared, lines_total, score and game_over in the same cycle; return to IDLE.
- Score increments, indexed by cleared:
  - 0 -> 0, 1 -> 40, 2 -> 100, 3 -> 300, 4 -> 1200.
  - Score saturates at SCORE_MAX; lines_total saturates at 16'hFFFF.
- game_over: set in DONE if cleared == 0 and any accepted in-range cell had y <= 1. Cleared only by reset.
- Access rule: at most one of row_rd_en / row_wr_en is high per cycle.
- Latency: accept-to-clear_done ≤ 1 + 12 + 3*ROWS + ROWS + 1 cycles (= 94 at the defaults).
- Reset mid-operation: abort immediately. The board may hold a partially compacted state; the top level must also reset the board storage.

Decomposition:
- Shared game package:
  - block_color enum, with EMPTY = 0.
  - ROWS and COLS constants.
  - Score-table constants.
- Sub-module row_full_detect:
  - Combinational; COLS*COLOR_W row in, full flag out.
  - Reused by render and debug logic.

Test Plan:
- Empty board, lock T at x={4,5,5,6}, y={19,18,19,19}, color MAGENTA:
  - Row 19 gets cells 4,5,6 = MAGENTA; row 18 gets cell 5.
  - lines_cleared = 0, score = 0, clear_done pulses once.
- Row 19 pre-filled in cols 0..5 and 9, lock I horizontal at y=19, x={6,7,8,9 overlap avoided → 6,7,8 plus cell at 18}:
  - Row 19 becomes full and is removed; old row 18 moves to 19; row 0 becomes EMPTY.
  - lines_cleared = 1, score = 40.
- Rows 16..19 full except col 0, lock vertical I at x=0, y=16..19:
  - lines_cleared = 4, score += 1200, lines_total += 4, rows 0..3 EMPTY.
- Non-adjacent clears, rows 19 and 17 full after lock:
  - Old row 18 lands in 19; old row 16 lands in 18; rows 0..1 EMPTY.
  - lines_cleared = 2, score += 100.
- lock_req pulsed during BOARD_BUSY:
  - Ignored; exactly one clear_done.
  - Score saturation: score preset at 999000 plus a tetris → score = 999999.
- Lock with a cell at y=1 and no clears:
  - game_over = 1 and remains 1.
  - Assert Reset low mid-scan: all outputs 0 immediately (asynchronous) and FSM in IDLE.

Source files
------------

// File: rtl/line_clear_engine_pkg.sv
// line_clear_engine_pkg
//   Shared game definitions for the board / line-clear logic:
//   - board geometry (ROWS, COLS) and cell width (COLOR_W)
//   - block_color_t, with EMPTY encoded as 0
//   - score table for 0..4 cleared rows
//   - engine FSM state encoding (also exported on the debug port)
//   - next_cell helper used to skip off-board cells of a locked piece
package line_clear_engine_pkg;

  localparam int ROWS      = 20;
  localparam int COLS      = 10;
  localparam int COLOR_W   = 3;
  localparam int SCORE_MAX = 999999;

  typedef enum logic [2:0] {
    EMPTY   = 3'd0,
    CYAN    = 3'd1,
    YELLOW  = 3'd2,
    MAGENTA = 3'd3,
    GREEN   = 3'd4,
    RED     = 3'd5,
    BLUE    = 3'd6,
    ORANGE  = 3'd7
  } block_color_t;

  localparam logic [10:0] SCORE_0 = 11'd0;
  localparam logic [10:0] SCORE_1 = 11'd40;
  localparam logic [10:0] SCORE_2 = 11'd100;
  localparam logic [10:0] SCORE_3 = 11'd300;
  localparam logic [10:0] SCORE_4 = 11'd1200;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LK_RD   = 4'd1,
    S_LK_WAIT = 4'd2,
    S_LK_WR   = 4'd3,
    S_SC_RD   = 4'd4,
    S_SC_WAIT = 4'd5,
    S_SC_EVAL = 4'd6,
    S_FILL    = 4'd7,
    S_DONE    = 4'd8
  } lce_state_t;

  // Points awarded for one operation; anything beyond four rows is
  // treated like a tetris.
  function automatic logic [10:0] score_for(input logic [4:0] n);
    logic [10:0] s;
    case (n)
      5'd0:    s = SCORE_0;
      5'd1:    s = SCORE_1;
      5'd2:    s = SCORE_2;
      5'd3:    s = SCORE_3;
      default: s = SCORE_4;
    endcase
    return s;
  endfunction

  // Lowest set index of mask that is >= from; 3'd4 means none left.
  function automatic logic [2:0] next_cell(input logic [3:0] mask,
                                           input logic [2:0] from);
    logic [2:0] r;
    r = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/line_clear_engine_row_full_detect.sv
// row_full_detect
//   Combinational: flags a board row whose every cell is non-EMPTY.
//   Ports:
//     row  in  COLS*COLOR_W  packed row, cell k at [k*COLOR_W +: COLOR_W]
//     full out 1             all COLS cells nonzero
module row_full_detect #(
  parameter int COLS    = 10,
  parameter int COLOR_W = 3
) (
  input  logic [COLS*COLOR_W-1:0] row,
  output logic                    full
);
  import line_clear_engine_pkg::*;

  always_comb begin
    full = 1'b1;
    for (int k = 0; k < COLS; k++) begin
      if (row[k*COLOR_W +: COLOR_W] == COLOR_W'(EMPTY)) full = 1'b0;
    end
  end

endmodule

// File: rtl/line_clear_engine.sv
// line_clear_engine
//   Commits a landed tetromino into board row storage, then removes full
//   rows by compacting the board downwards and back-filling the top with
//   EMPTY rows. Maintains score, line total and the sticky top-out flag.
//
//   Ports:
//     Clk, Reset            clock, asynchronous active-low reset
//     lock_req              1-cycle request pulse, only honoured when idle
//     lock_x, lock_y        four 5-bit coordinates {c3,c2,c1,c0}
//     lock_color            piece color
//     row_rd_en/addr/data   board read port, data valid 1 cycle after en
//     row_wr_en/addr/data   board write port
//     BOARD_BUSY            high while an operation is in progress
//     clear_done            1-cycle completion pulse
//     lines_cleared         rows removed by the last operation
//     lines_total, score    saturating totals
//     game_over             sticky top-out flag
//     fsm_state             current FSM state (debug)
//
//   Handshake: lock_req has no ready; a pulse is accepted only in a cycle
//   where BOARD_BUSY is low. The board ports are plain strobes: a read
//   strobe in cycle t returns row_rd_data in cycle t+1, a write strobe
//   commits at the end of its cycle, and the two are never high together.
module line_clear_engine #(
  parameter int ROWS      = 20,
  parameter int COLS      = 10,
  parameter int COLOR_W   = 3,
  parameter int SCORE_MAX = 999999
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    lock_req,
  input  logic [19:0]             lock_x,
  input  logic [19:0]             lock_y,
  input  logic [COLOR_W-1:0]      lock_color,
  output logic                    row_rd_en,
  output logic [4:0]              row_rd_addr,
  input  logic [COLS*COLOR_W-1:0] row_rd_data,
  output logic                    row_wr_en,
  output logic [4:0]              row_wr_addr,
  output logic [COLS*COLOR_W-1:0] row_wr_data,
  output logic                    BOARD_BUSY,
  output logic                    clear_done,
  output logic [2:0]              lines_cleared,
  output logic [15:0]             lines_total,
  output logic [19:0]             score,
  output logic                    game_over,
  output logic [3:0]              fsm_state
);
  import line_clear_engine_pkg::*;

  localparam int          RW        = COLS * COLOR_W;
  localparam logic [4:0]  ROWS_L    = 5'(ROWS);
  localparam logic [4:0]  COLS_L    = 5'(COLS);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [19:0] SCORE_SAT = 20'(SCORE_MAX);

  lce_state_t state_q, state_d;

  logic [19:0]        lx_q, ly_q;
  logic [COLOR_W-1:0] color_q;
  logic [3:0]         valid_q;      // in-range cells of the accepted piece
  logic               top_hit_q;    // some in-range cell had y <= 1
  logic [2:0]         cell_q;       // cell being committed, 4 = none
  logic [4:0]         src_q, dst_q, fill_q, cleared_q;
  logic [RW-1:0]      row_buf_q;

  logic [3:0]    valid_in;
  logic          top_hit_in;
  logic [2:0]    first_in, nxt_cell;
  logic [4:0]    cur_x, cur_y;
  logic [RW-1:0] row_mod;
  logic          row_full;
  logic [4:0]    cleared_next;
  logic [20:0]   score_sum;
  logic [16:0]   total_sum;
  logic          enter_done;

  row_full_detect #(.COLS(COLS), .COLOR_W(COLOR_W)) u_full (
    .row  (row_buf_q),
    .full (row_full)
  );

  // Cells outside the board are dropped at acceptance so the commit loop
  // can jump straight over them.
  always_comb begin
    valid_in   = '0;
    top_hit_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_in[i] = (lock_x[i*5 +: 5] < COLS_L) && (lock_y[i*5 +: 5] < ROWS_L);
      if (valid_in[i] && (lock_y[i*5 +: 5] <= 5'd1)) top_hit_in = 1'b1;
    end
  end

  assign first_in = next_cell(valid_in, 3'd0);
  assign nxt_cell = next_cell(valid_q, cell_q + 3'd1);

  always_comb begin
    cur_x = '0;
    cur_y = '0;
    case (cell_q[1:0])
      2'd0: begin cur_x = lx_q[4:0];   cur_y = ly_q[4:0];   end
      2'd1: begin cur_x = lx_q[9:5];   cur_y = ly_q[9:5];   end
      2'd2: begin cur_x = lx_q[14:10]; cur_y = ly_q[14:10]; end
      default: begin cur_x = lx_q[19:15]; cur_y = ly_q[19:15]; end
    endcase
  end

  // Row after dropping the current cell into it.
  always_comb begin
    row_mod = row_buf_q;
    for (int k = 0; k < COLS; k++) begin
      if (cur_x == 5'(k)) row_mod[k*COLOR_W +: COLOR_W] = color_q;
    end
  end

  // The last SC_EVAL and the DONE bookkeeping share an edge, so the
  // totals are taken from the count including the row being evaluated.
  assign cleared_next = cleared_q + {4'd0, (state_q == S_SC_EVAL) && row_full};
  assign score_sum    = {1'b0, score} + {10'd0, score_for(cleared_next)};
  assign total_sum    = {1'b0, lines_total} + {12'd0, cleared_next};
  assign enter_done   = (state_d == S_DONE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    row_rd_en   = 1'b0;
    row_rd_addr = '0;
    row_wr_en   = 1'b0;
    row_wr_addr = '0;
    row_wr_data = '0;
    case (state_q)
      S_IDLE: begin
        if (lock_req) state_d = (first_in != 3'd4) ? S_LK_RD : S_SC_RD;
      end
      S_LK_RD: begin
        row_rd_en   = 1'b1;
        row_rd_addr = cur_y;
        state_d     = S_LK_WAIT;
      end
      S_LK_WAIT: state_d = S_LK_WR;
      S_LK_WR: begin
        row_wr_en   = 1'b1;
        row_wr_addr = cur_y;
        row_wr_data = row_mod;
        state_d     = (nxt_cell != 3'd4) ? S_LK_RD : S_SC_RD;
      end
      S_SC_RD: begin
        row_rd_en   = 1'b1;
        row_rd_addr = src_q;
        state_d     = S_SC_WAIT;
      end
      S_SC_WAIT: state_d = S_SC_EVAL;
      S_SC_EVAL: begin
        if (!row_full && (src_q != dst_q)) begin
          row_wr_en   = 1'b1;
          row_wr_addr = dst_q;
          row_wr_data = row_buf_q;
        end
        if (src_q == 5'd0) state_d = (cleared_next != 5'd0) ? S_FILL : S_DONE;
        else               state_d = S_SC_RD;
      end
      S_FILL: begin
        row_wr_en   = 1'b1;
        row_wr_addr = fill_q;
        if (fill_q == dst_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign BOARD_BUSY = (state_q != S_IDLE);
  assign clear_done = (state_q == S_DONE);
  assign fsm_state  = state_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      lx_q          <= '0;
      ly_q          <= '0;
      color_q       <= '0;
      valid_q       <= '0;
      top_hit_q     <= 1'b0;
      cell_q        <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      fill_q        <= '0;
      cleared_q     <= '0;
      row_buf_q     <= '0;
      lines_cleared <= '0;
      lines_total   <= '0;
      score         <= '0;
      game_over     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (lock_req) begin
            lx_q      <= lock_x;
            ly_q      <= lock_y;
            color_q   <= lock_color;
            valid_q   <= valid_in;
            top_hit_q <= top_hit_in;
            cell_q    <= first_in;
            src_q     <= LAST_ROW;
            dst_q     <= LAST_ROW;
            fill_q    <= '0;
            cleared_q <= '0;
          end
        end
        S_LK_WAIT, S_SC_WAIT: row_buf_q <= row_rd_data;
        S_LK_WR:   cell_q <= nxt_cell;
        S_SC_EVAL: begin
          cleared_q <= cleared_next;
          if (!row_full) dst_q <= dst_q - 5'd1;
          src_q <= src_q - 5'd1;
        end
        S_FILL:  fill_q <= fill_q + 5'd1;
        default: ;
      endcase

      // Results appear together with the clear_done pulse.
      if (enter_done) begin
        lines_cleared <= (cleared_next > 5'd7) ? 3'd7 : cleared_next[2:0];
        lines_total   <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
        score         <= (score_sum > {1'b0, SCORE_SAT}) ? SCORE_SAT : score_sum[19:0];
        if ((cleared_next == 5'd0) && top_hit_q) game_over <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_line_clear_engine.sv
module tb_line_clear_engine;
  localparam int NR   = 20;
  localparam int NC   = 10;
  localparam int SMAX = 3000;  // low ceiling so saturation is reachable

  logic        Clk, Reset;
  logic        lock_req;
  logic [19:0] lock_x, lock_y;
  logic [2:0]  lock_color;
  logic        row_rd_en, row_wr_en;
  logic [4:0]  row_rd_addr, row_wr_addr;
  logic [29:0] row_rd_data, row_wr_data;
  logic        BOARD_BUSY, clear_done, game_over;
  logic [2:0]  lines_cleared;
  logic [15:0] lines_total;
  logic [19:0] score;
  logic [3:0]  fsm_state;

  line_clear_engine #(.SCORE_MAX(SMAX)) dut (
    .Clk(Clk), .Reset(Reset), .lock_req(lock_req), .lock_x(lock_x),
    .lock_y(lock_y), .lock_color(lock_color), .row_rd_en(row_rd_en),
    .row_rd_addr(row_rd_addr), .row_rd_data(row_rd_data),
    .row_wr_en(row_wr_en), .row_wr_addr(row_wr_addr),
    .row_wr_data(row_wr_data), .BOARD_BUSY(BOARD_BUSY),
    .clear_done(clear_done), .lines_cleared(lines_cleared),
    .lines_total(lines_total), .score(score), .game_over(game_over),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // ---------------- board storage ----------------
  logic [29:0] mem [NR];
  logic        tb_we;
  logic [4:0]  tb_wa;
  logic [29:0] tb_wd;
  int          both_cnt;

  always @(posedge Clk) begin
    if (row_wr_en)  mem[row_wr_addr] <= row_wr_data;
    else if (tb_we) mem[tb_wa] <= tb_wd;
    if (row_rd_en)  row_rd_data <= mem[row_rd_addr];
  end

  always @(negedge Clk) if (row_rd_en && row_wr_en) both_cnt++;

  // ---------------- reference model ----------------
  int mb [NR][NC];
  int exp_score, exp_total, exp_lines, exp_go;
  logic [29:0] exp_q [$];
  int nchk, nerr;

  function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic logic [29:0] mk_row(input int mask, input int col);
    logic [29:0] r;
    r = '0;
    for (int k = 0; k < NC; k++)
      if (((mask >> k) & 1) != 0)
        r[k*3 +: 3] = (col == 0) ? 3'($urandom_range(1, 7)) : 3'(col);
    return r;
  endfunction

  // Lock the piece, drop every full row, let everything above fall.
  task automatic model_lock(input logic [19:0] xs, input logic [19:0] ys, input int col);
    int nb [NR][NC];
    int hit, cl, w, x, y, full;
    int tbl [5] = '{0, 40, 100, 300, 1200};
    logic [29:0] row;
    hit = 0;
    for (int i = 0; i < 4; i++) begin
      x = int'(xs[i*5 +: 5]);
      y = int'(ys[i*5 +: 5]);
      if (x < NC && y < NR) begin
        mb[y][x] = col;
        if (y <= 1) hit = 1;
      end
    end
    for (int r = 0; r < NR; r++) for (int k = 0; k < NC; k++) nb[r][k] = 0;
    cl = 0;
    w  = NR - 1;
    for (int r = NR - 1; r >= 0; r--) begin
      full = 1;
      for (int k = 0; k < NC; k++) if (mb[r][k] == 0) full = 0;
      if (full != 0) cl++;
      else begin
        for (int k = 0; k < NC; k++) nb[w][k] = mb[r][k];
        w--;
      end
    end
    mb = nb;
    exp_lines = cl;
    exp_score = exp_score + tbl[(cl > 4) ? 4 : cl];
    if (exp_score > SMAX) exp_score = SMAX;
    exp_total = exp_total + cl;
    if (cl == 0 && hit != 0) exp_go = 1;
    for (int r = 0; r < NR; r++) begin
      row = '0;
      for (int k = 0; k < NC; k++) row[k*3 +: 3] = 3'(mb[r][k]);
      exp_q.push_back(row);
    end
  endtask

  // Number of stored rows that differ from the expected board.
  function automatic int rows_wrong();
    int n;
    logic [29:0] e;
    n = 0;
    for (int r = 0; r < NR; r++) begin
      e = exp_q.pop_front();
      if (mem[r] !== e) n++;
    end
    return n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_row(input int r, input logic [29:0] d);
    @(negedge Clk);
    tb_we = 1'b1; tb_wa = 5'(r); tb_wd = d;
    @(negedge Clk);
    tb_we = 1'b0;
    for (int k = 0; k < NC; k++) mb[r][k] = int'(d[k*3 +: 3]);
  endtask

  task automatic clear_board();
    for (int r = 0; r < NR; r++) set_row(r, '0);
  endtask

  // Issue one lock and follow it to clear_done; optionally pulse lock_req
  // again (with a different piece) while the engine is busy.
  task automatic run_lock(input logic [19:0] xs, input logic [19:0] ys, input logic [2:0] col,
                          input int pulse_at, output int lat, output int ndone);
    lat = -1; ndone = 0;
    @(negedge Clk);
    lock_x = xs; lock_y = ys; lock_color = col; lock_req = 1'b1;
    @(negedge Clk);
    lock_req = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (clear_done === 1'b1) begin
        ndone++;
        if (lat < 0) lat = c;
      end
      if (lat >= 0 && c >= lat + 4) break;
      lock_req = (c == pulse_at);
      if (c == pulse_at) begin lock_x = pk(1, 2, 3, 4); lock_y = pk(10, 10, 10, 10); end
      @(negedge Clk);
    end
    lock_req = 1'b0;
  endtask

  task automatic setup_tetris();
    clear_board();
    for (int r = 16; r < 20; r++) set_row(r, mk_row(10'h3FE, 0));
    set_row(15, mk_row(10'h0F0, 2));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    nchk++;
    if ({BOARD_BUSY, clear_done, row_rd_en, row_wr_en, game_over} !== 5'b0) begin
      nerr++; $display("FAIL reset_flags got %b exp 00000", {BOARD_BUSY, clear_done, row_rd_en, row_wr_en, game_over});
    end
    nchk++;
    if ({lines_cleared, lines_total, score} !== 39'b0) begin
      nerr++; $display("FAIL reset_counts got lc=%0d lt=%0d sc=%0d exp 0", lines_cleared, lines_total, score);
    end
    Reset = 1'b1;
    @(negedge Clk);
    nchk++;
    if (fsm_state !== 4'd0 || BOARD_BUSY !== 1'b0) begin
      nerr++; $display("FAIL reset_idle got state=%0d busy=%b exp 0/0", fsm_state, BOARD_BUSY);
    end
  endtask

  task automatic test_t_piece();
    int lat, nd;
    logic [19:0] xs, ys;
    clear_board();
    xs = pk(4, 5, 5, 6); ys = pk(19, 18, 19, 19);
    run_lock(xs, ys, 3'd3, 0, lat, nd);
    model_lock(xs, ys, 3);
    nchk++; if (nd !== 1) begin nerr++; $display("FAIL t_done got %0d exp 1", nd); end
    nchk++; if (rows_wrong() !== 0) begin nerr++; $display("FAIL t_board rows differ"); end
    nchk++;
    if (lines_cleared !== 3'(exp_lines) || score !== 20'(exp_score)) begin
      nerr++; $display("FAIL t_stats got lc=%0d sc=%0d exp %0d/%0d", lines_cleared, score, exp_lines, exp_score);
    end
    nchk++; if (lat < 1 || lat > 94) begin nerr++; $display("FAIL t_latency got %0d exp <=94", lat); end
    nchk++; if (BOARD_BUSY !== 1'b0) begin nerr++; $display("FAIL t_busy_after got %b exp 0", BOARD_BUSY); end
  endtask

  task automatic test_single_clear();
    int lat, nd;
    logic [19:0] xs, ys;
    clear_board();
    set_row(19, mk_row(10'h23F, 1));
    xs = pk(6, 7, 8, 5); ys = pk(19, 19, 19, 18);
    run_lock(xs, ys, 3'd2, 0, lat, nd);
    model_lock(xs, ys, 2);
    nchk++; if (rows_wrong() !== 0) begin nerr++; $display("FAIL single_board rows differ"); end
    nchk++;
    if (lines_cleared !== 3'(exp_lines) || score !== 20'(exp_score) || exp_lines != 1) begin
      nerr++; $display("FAIL single_stats got lc=%0d sc=%0d exp %0d/%0d", lines_cleared, score, exp_lines, exp_score);
    end
  endtask

  task automatic test_tetris();
    int lat, nd;
    logic [19:0] xs, ys;
    setup_tetris();
    xs = pk(0, 0, 0, 0); ys = pk(16, 17, 18, 19);
    run_lock(xs, ys, 3'd1, 0, lat, nd);
    model_lock(xs, ys, 1);
    nchk++; if (rows_wrong() !== 0) begin nerr++; $display("FAIL tetris_board rows differ"); end
    nchk++;
    if (lines_cleared !== 3'(exp_lines) || score !== 20'(exp_score) || lines_total !== 16'(exp_total)) begin
      nerr++; $display("FAIL tetris_stats got lc=%0d sc=%0d lt=%0d exp %0d/%0d/%0d",
                       lines_cleared, score, lines_total, exp_lines, exp_score, exp_total);
    end
    nchk++; if (lat > 94) begin nerr++; $display("FAIL tetris_latency got %0d exp <=94", lat); end
  endtask

  task automatic test_nonadjacent();
    int lat, nd;
    logic [19:0] xs, ys;
    clear_board();
    set_row(19, mk_row(10'h3FE, 0));
    set_row(18, mk_row(10'h00C, 4));
    set_row(17, mk_row(10'h3FE, 0));
    set_row(16, mk_row(10'h300, 5));
    // cell 3 is off the board (x=31) and must be skipped
    xs = pk(0, 0, 3, 31); ys = pk(19, 17, 10, 5);
    run_lock(xs, ys, 3'd6, 0, lat, nd);
    model_lock(xs, ys, 6);
    nchk++; if (rows_wrong() !== 0) begin nerr++; $display("FAIL nonadj_board rows differ"); end
    nchk++;
    if (lines_cleared !== 3'(exp_lines) || score !== 20'(exp_score)) begin
      nerr++; $display("FAIL nonadj_stats got lc=%0d sc=%0d exp %0d/%0d", lines_cleared, score, exp_lines, exp_score);
    end
  endtask

  task automatic test_busy_ignore();
    int lat, nd;
    logic [19:0] xs, ys;
    clear_board();
    xs = pk(2, 3, 4, 5); ys = pk(19, 19, 19, 19);
    run_lock(xs, ys, 3'd7, 10, lat, nd);
    model_lock(xs, ys, 7);
    nchk++; if (nd !== 1) begin nerr++; $display("FAIL busy_done_count got %0d exp 1", nd); end
    nchk++; if (rows_wrong() !== 0) begin nerr++; $display("FAIL busy_board rows differ"); end
  endtask

  task automatic test_saturation();
    int lat, nd;
    for (int n = 0; n < 2; n++) begin
      setup_tetris();
      run_lock(pk(0, 0, 0, 0), pk(16, 17, 18, 19), 3'd1, 0, lat, nd);
      model_lock(pk(0, 0, 0, 0), pk(16, 17, 18, 19), 1);
      nchk++; if (rows_wrong() !== 0) begin nerr++; $display("FAIL sat_board rows differ"); end
      nchk++;
      if (score !== 20'(exp_score)) begin
        nerr++; $display("FAIL sat_score got %0d exp %0d", score, exp_score);
      end
    end
  endtask

  task automatic test_game_over();
    int lat, nd;
    clear_board();
    run_lock(pk(0, 1, 2, 3), pk(1, 2, 3, 4), 3'd4, 0, lat, nd);
    model_lock(pk(0, 1, 2, 3), pk(1, 2, 3, 4), 4);
    nchk++; if (game_over !== 1'(exp_go)) begin nerr++; $display("FAIL go_set got %b exp %0d", game_over, exp_go); end
    nchk++; if (rows_wrong() !== 0) begin nerr++; $display("FAIL go_board rows differ"); end
    run_lock(pk(7, 7, 7, 7), pk(19, 18, 17, 16), 3'd5, 0, lat, nd);
    model_lock(pk(7, 7, 7, 7), pk(19, 18, 17, 16), 5);
    void'(rows_wrong());
    nchk++; if (game_over !== 1'(exp_go)) begin nerr++; $display("FAIL go_sticky got %b exp %0d", game_over, exp_go); end
  endtask

  task automatic test_random();
    int lat, nd, mask;
    logic [19:0] xs, ys;
    logic [2:0] col;
    for (int it = 0; it < 8; it++) begin
      clear_board();
      for (int r = 15; r < 20; r++) begin
        if ($urandom_range(0, 2) != 0) mask = 10'h3FF ^ (1 << $urandom_range(0, 9));
        else mask = $urandom_range(0, 1023);
        set_row(r, mk_row(mask, 0));
      end
      xs = pk($urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11));
      ys = pk($urandom_range(14, 21), $urandom_range(14, 21), $urandom_range(14, 21), $urandom_range(14, 21));
      col = 3'($urandom_range(1, 7));
      run_lock(xs, ys, col, 0, lat, nd);
      model_lock(xs, ys, int'(col));
      nchk++; if (rows_wrong() !== 0) begin nerr++; $display("FAIL rand%0d_board rows differ", it); end
      nchk++;
      if (nd !== 1 || lines_cleared !== 3'(exp_lines) || score !== 20'(exp_score) || lines_total !== 16'(exp_total)) begin
        nerr++; $display("FAIL rand%0d_stats got nd=%0d lc=%0d sc=%0d lt=%0d exp 1/%0d/%0d/%0d",
                         it, nd, lines_cleared, score, lines_total, exp_lines, exp_score, exp_total);
      end
    end
    nchk++; if (both_cnt !== 0) begin nerr++; $display("FAIL access_rule got %0d overlaps exp 0", both_cnt); end
  endtask

  task automatic test_reset_mid();
    int lat, nd;
    setup_tetris();
    @(negedge Clk);
    lock_x = pk(0, 0, 0, 0); lock_y = pk(16, 17, 18, 19); lock_color = 3'd1; lock_req = 1'b1;
    @(negedge Clk);
    lock_req = 1'b0;
    repeat (40) @(negedge Clk);
    nchk++; if (BOARD_BUSY !== 1'b1) begin nerr++; $display("FAIL midrst_busy_before got %b exp 1", BOARD_BUSY); end
    #2 Reset = 1'b0;
    #1;
    nchk++;
    if (fsm_state !== 4'd0 || {BOARD_BUSY, row_rd_en, row_wr_en, game_over} !== 4'b0 ||
        score !== 20'd0 || lines_total !== 16'd0) begin
      nerr++; $display("FAIL midrst_async got st=%0d busy=%b go=%b sc=%0d lt=%0d exp all 0",
                       fsm_state, BOARD_BUSY, game_over, score, lines_total);
    end
    @(negedge Clk);
    Reset = 1'b1;
    exp_score = 0; exp_total = 0; exp_go = 0; exp_lines = 0;
    clear_board();
    run_lock(pk(3, 4, 5, 6), pk(19, 19, 19, 19), 3'd2, 0, lat, nd);
    model_lock(pk(3, 4, 5, 6), pk(19, 19, 19, 19), 2);
    nchk++; if (rows_wrong() !== 0) begin nerr++; $display("FAIL midrst_after_board rows differ"); end
    nchk++; if (nd !== 1) begin nerr++; $display("FAIL midrst_after_done got %0d exp 1", nd); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    nchk = 0; nerr = 0; both_cnt = 0;
    exp_score = 0; exp_total = 0; exp_lines = 0; exp_go = 0;
    lock_req = 1'b0; lock_x = '0; lock_y = '0; lock_color = '0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    for (int r = 0; r < NR; r++) for (int k = 0; k < NC; k++) mb[r][k] = 0;
    test_reset();
    test_t_piece();
    test_single_clear();
    test_tetris();
    test_nonadjacent();
    test_busy_ignore();
    test_saturation();
    test_game_over();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
